// File: rtl/dec_scan_sequencer_pkg.sv
// Shared types and constants for the decoder scan sequencer.
// Mode and FSM encodings used by the top, the timer and the interface.
package dec_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DN   = 2'b01,
    MODE_ONE  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dec_scan_sequencer_if.sv
// Control/status bundle between a scan controller and the sequencer.
// The sequencer takes the slave side and drives the decoder select code.
interface dec_scan_if #(
  parameter int DWELL_W = 8
);
  import dec_pkg::*;

  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic [CODE_W-1:0]  code;
  logic               code_valid;
  logic               busy;
  logic               sweep_done;

  modport master (
    output start, stop, mode, dwell,
    input  code, code_valid, busy, sweep_done
  );

  modport slave (
    input  start, stop, mode, dwell,
    output code, code_valid, busy, sweep_done
  );

endinterface

// File: rtl/dec_scan_sequencer_timer.sv
// Per-code dwell counter; expire_o marks the last cycle of a dwell.
// A dwell of zero behaves as a dwell of one.
module dec_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] last;

  always_comb begin
    if (dwell_i == '0) last = '0;
    else               last = dwell_i - DWELL_W'(1);
  end

  assign expire_o = (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)        cnt_d = '0;
    else if (en_i) begin
      if (expire_o)    cnt_d = '0;
      else             cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dec_scan_sequencer.sv
// Select-code sequencer feeding a 4-to-16 decoder.
// Steps codes 0..LAST_CODE with a programmable dwell per code.
module dec_scan_sequencer
  import dec_pkg::*;
#(
  parameter int DWELL_W   = 8,
  parameter int LAST_CODE = 15
) (
  input  logic clk,
  input  logic rst,
  dec_scan_if.slave scan_io
);

  localparam logic [CODE_W-1:0] LAST = CODE_W'(LAST_CODE);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               sd_q, sd_d;
  logic               load;
  logic               expire;
  logic               go;

  assign go = scan_io.start && !scan_io.stop;

  dec_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .en_i     (state_q == ST_RUN),
    .dwell_i  (dwell_q),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_UP;
      dwell_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      sd_q    <= sd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (go) state_d = ST_RUN;
      ST_RUN: begin
        if (scan_io.stop)
          state_d = ST_IDLE;
        else if (mode_q == MODE_ONE
                 && expire && code_q == LAST)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    sd_d    = 1'b0;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          mode_d  = mode_e'(scan_io.mode);
          dwell_d = scan_io.dwell;
          code_d  = (mode_e'(scan_io.mode) == MODE_DN)
                    ? LAST : '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (scan_io.stop) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (expire) begin
          unique case (1'b1)
            (mode_q == MODE_UP): begin
              if (code_q == LAST) begin
                code_d = '0;
                sd_d   = 1'b1;
              end else begin
                code_d = code_q + CODE_W'(1);
              end
            end
            (mode_q == MODE_DN): begin
              if (code_q == '0) begin
                code_d = LAST;
                sd_d   = 1'b1;
              end else begin
                code_d = code_q - CODE_W'(1);
              end
            end
            (mode_q == MODE_ONE): begin
              // last code of a single sweep: retire but keep the code
              if (code_q == LAST) begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                sd_d    = 1'b1;
              end else begin
                code_d = code_q + CODE_W'(1);
              end
            end
            (mode_q == MODE_HOLD): ;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign scan_io.code       = code_q;
  assign scan_io.code_valid = valid_q;
  assign scan_io.busy       = busy_q;
  assign scan_io.sweep_done = sd_q;

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Directed bench for dec_scan_sequencer.
// Two instances: LAST_CODE=15 and LAST_CODE=9.
module tb_dec_scan_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dec_scan_if #(.DWELL_W(8)) if0 ();
  dec_scan_if #(.DWELL_W(8)) if9 ();

  dec_scan_sequencer #(
    .DWELL_W   (8),
    .LAST_CODE (15)
  ) u0 (
    .clk     (clk),
    .rst     (rst),
    .scan_io (if0.slave)
  );

  dec_scan_sequencer #(
    .DWELL_W   (8),
    .LAST_CODE (9)
  ) u9 (
    .clk     (clk),
    .rst     (rst),
    .scan_io (if9.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start0(input logic [1:0] m,
                        input logic [7:0] d);
    if0.mode  = m;
    if0.dwell = d;
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    if (if0.code !== 4'd0) begin
      errors++;
      $display("FAIL rst_code got %0d exp 0", if0.code);
    end
    checks++;
    if (if0.code_valid !== 1'b0 || if0.busy !== 1'b0
        || if0.sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got v%b b%b s%b exp 000",
               if0.code_valid, if0.busy, if0.sweep_done);
    end
    checks++;
    if (if9.code !== 4'd0 || if9.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_u9 got c%0d b%b exp c0 b0",
               if9.code, if9.busy);
    end
    checks++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_rst_midscan();
    start0(2'b00, 8'd1);
    repeat (4) step();
    rst = 1'b1;
    step();
    if (if0.code !== 4'd0 || if0.code_valid !== 1'b0
        || if0.busy !== 1'b0 || if0.sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst got c%0d v%b b%b s%b exp 0000",
               if0.code, if0.code_valid, if0.busy,
               if0.sweep_done);
    end
    checks++;
    repeat (2) step();
    rst = 1'b0;
    start0(2'b00, 8'd2);
    if (if0.code !== 4'd0 || if0.code_valid !== 1'b1
        || if0.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_start got c%0d v%b b%b exp c0 v1 b1",
               if0.code, if0.code_valid, if0.busy);
    end
    checks++;
    step();
    if (if0.code !== 4'd0) begin
      errors++;
      $display("FAIL midrst_hold got %0d exp 0", if0.code);
    end
    checks++;
    step();
    if (if0.code !== 4'd1) begin
      errors++;
      $display("FAIL midrst_step got %0d exp 1", if0.code);
    end
    checks++;
    if0.stop = 1'b1;
    step();
    if0.stop = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] ec;
    logic       es;
    start0(2'b00, 8'd3);
    for (int i = 0; i <= 48; i++) begin
      ec = 4'((i / 3) % 16);
      es = (i == 48);
      if (if0.code !== ec || if0.sweep_done !== es
          || if0.code_valid !== 1'b1) begin
        errors++;
        $display("FAIL up_wrap[%0d] got c%0d s%b v%b exp c%0d s%b v1",
                 i, if0.code, if0.sweep_done, if0.code_valid,
                 ec, es);
      end
      checks++;
      if (i != 48) step();
    end
    if0.stop = 1'b1;
    step();
    if0.stop = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] ec;
    logic       es;
    if9.mode  = 2'b01;
    if9.dwell = 8'd0;
    if9.start = 1'b1;
    step();
    if9.start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      ec = (i <= 9) ? 4'(9 - i) : 4'd9;
      es = (i == 10);
      if (if9.code !== ec || if9.sweep_done !== es) begin
        errors++;
        $display("FAIL dn_wrap[%0d] got c%0d s%b exp c%0d s%b",
                 i, if9.code, if9.sweep_done, ec, es);
      end
      checks++;
      if (i != 10) step();
    end
    if9.stop = 1'b1;
    step();
    if9.stop = 1'b0;
    if (if9.busy !== 1'b0 || if9.code !== 4'd9) begin
      errors++;
      $display("FAIL dn_stop got b%b c%0d exp b0 c9",
               if9.busy, if9.code);
    end
    checks++;
  endtask

  task automatic test_single();
    logic [3:0] ec;
    start0(2'b10, 8'd2);
    for (int i = 0; i < 32; i++) begin
      ec = 4'(i / 2);
      if (if0.code !== ec || if0.sweep_done !== 1'b0
          || if0.busy !== 1'b1) begin
        errors++;
        $display("FAIL single[%0d] got c%0d s%b b%b exp c%0d s0 b1",
                 i, if0.code, if0.sweep_done, if0.busy, ec);
      end
      checks++;
      step();
    end
    if (if0.code !== 4'd15 || if0.code_valid !== 1'b0
        || if0.busy !== 1'b0 || if0.sweep_done !== 1'b1) begin
      errors++;
      $display("FAIL single_end got c%0d v%b b%b s%b exp c15 v0 b0 s1",
               if0.code, if0.code_valid, if0.busy,
               if0.sweep_done);
    end
    checks++;
    step();
    if (if0.code !== 4'd15 || if0.sweep_done !== 1'b0
        || if0.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after got c%0d s%b b%b exp c15 s0 b0",
               if0.code, if0.sweep_done, if0.busy);
    end
    checks++;
  endtask

  task automatic test_stop();
    start0(2'b00, 8'd1);
    repeat (2) step();
    if0.mode  = 2'b01;
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    if (if0.code !== 4'd3 || if0.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run got c%0d b%b exp c3 b1",
               if0.code, if0.busy);
    end
    checks++;
    repeat (2) step();
    if0.stop = 1'b1;
    step();
    if0.stop = 1'b0;
    if (if0.code !== 4'd5 || if0.code_valid !== 1'b0
        || if0.busy !== 1'b0 || if0.sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL stop5 got c%0d v%b b%b s%b exp c5 v0 b0 s0",
               if0.code, if0.code_valid, if0.busy,
               if0.sweep_done);
    end
    checks++;
    if0.start = 1'b1;
    if0.stop  = 1'b1;
    step();
    if0.start = 1'b0;
    if0.stop  = 1'b0;
    if (if0.busy !== 1'b0 || if0.code_valid !== 1'b0
        || if0.code !== 4'd5) begin
      errors++;
      $display("FAIL start_stop got b%b v%b c%0d exp b0 v0 c5",
               if0.busy, if0.code_valid, if0.code);
    end
    checks++;
    start0(2'b00, 8'd1);
    repeat (15) step();
    if (if0.code !== 4'd15) begin
      errors++;
      $display("FAIL pre_wrap got %0d exp 15", if0.code);
    end
    checks++;
    if0.stop = 1'b1;
    step();
    if0.stop = 1'b0;
    if (if0.code !== 4'd15 || if0.sweep_done !== 1'b0
        || if0.code_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_wrap got c%0d s%b v%b exp c15 s0 v0",
               if0.code, if0.sweep_done, if0.code_valid);
    end
    checks++;
  endtask

  task automatic test_hold();
    start0(2'b11, 8'd4);
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin
        if0.mode  = 2'b00;
        if0.dwell = 8'd1;
        if0.start = 1'b1;
      end else begin
        if0.start = 1'b0;
      end
      if (if0.code !== 4'd0 || if0.sweep_done !== 1'b0
          || if0.code_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d] got c%0d s%b v%b exp c0 s0 v1",
                 i, if0.code, if0.sweep_done, if0.code_valid);
      end
      checks++;
      step();
    end
    if0.start = 1'b0;
    if0.stop  = 1'b1;
    step();
    if0.stop  = 1'b0;
    start0(2'b00, 8'd1);
    if (if0.code !== 4'd0) begin
      errors++;
      $display("FAIL hold_new0 got %0d exp 0", if0.code);
    end
    checks++;
    step();
    if (if0.code !== 4'd1) begin
      errors++;
      $display("FAIL hold_new1 got %0d exp 1", if0.code);
    end
    checks++;
    if0.stop = 1'b1;
    step();
    if0.stop = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    if0.start = 1'b0;
    if0.stop  = 1'b0;
    if0.mode  = 2'b00;
    if0.dwell = 8'd0;
    if9.start = 1'b0;
    if9.stop  = 1'b0;
    if9.mode  = 2'b00;
    if9.dwell = 8'd0;
    #1;
    test_reset();
    test_rst_midscan();
    test_up_wrap();
    test_down_wrap();
    test_single();
    test_stop();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
